// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a runtime-programmable bit period,
// feeding a small show-ahead FIFO. Frame and overrun errors are held in
// sticky flags until err_clr; a one-cycle rx_done marks each stored byte.
//
// state   | meaning
// S_IDLE  | line idle, waiting for rx_s to fall
// S_START | timing to the middle of the start bit to confirm it
// S_DATA  | sampling the 8 data bits, LSB first
// S_STOP  | sampling the stop bit; push, drop or flag the byte

module uart_rx_fifo #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic               rx,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count,
    output logic               rx_busy,
    output logic               rx_done,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               rx_meta;
    logic               rx_s;

    logic [DIV_W-1:0]   timer;
    logic [DIV_W-1:0]   div_q;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_q;

    logic               sample;
    logic               start_det;
    logic               shift_en;
    logic               push;
    logic               pop;
    logic               frm_set;
    logic               ovr_set;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    // A sample event is the bit timer reaching zero while a frame is active.
    assign sample = (state != S_IDLE) && (timer == '0);
    assign pop    = rd_en && !empty;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (sample) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample && (bit_idx == 3'd7)) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (sample) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: strobes for the timer, shifter, FIFO and flags.
    always_comb begin
        start_det = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        frm_set   = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            S_IDLE:  start_det = !rx_s;
            S_START: ;
            S_DATA:  shift_en  = sample;
            S_STOP: begin
                if (sample) begin
                    if (!rx_s) begin
                        frm_set = 1'b1;
                    end else if (!full || pop) begin
                        // A pop in the same cycle frees the slot this byte takes.
                        push = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_busy = (state != S_IDLE);

    // Bit timer: first expiry lands mid start bit, then one bit period apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            div_q <= '0;
        end else if (start_det) begin
            timer <= (clk_div >> 1) - DIV_W'(1);
            div_q <= clk_div;
        end else if (state != S_IDLE) begin
            if (timer == '0) begin
                timer <= div_q - DIV_W'(1);
            end else begin
                timer <= timer - DIV_W'(1);
            end
        end
    end

    // Data shifter: each sampled bit goes to its own position, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            shift_q <= '0;
        end else if (state == S_START && sample) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            shift_q[bit_idx] <= rx_s;
            bit_idx          <= bit_idx + 3'd1;
        end
    end

    // FIFO storage, pointers and occupancy; pointers wrap at the depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);

    // Completion pulse and sticky error flags; a new error beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_done <= push;
            if (frm_set)      frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized frames against a queue-based
// reference model of the receive FIFO and error flags.

module tb_uart_rx_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] clk_div;
    logic        rx;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        rx_busy;
    logic        rx_done;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;

    uart_rx_fifo #(.DIV_W(16), .FIFO_AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_div   (clk_div),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .rx_busy   (rx_busy),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int frame_start_cyc = 0;

    // Reference model: queue of stored bytes plus expected flags and pulses.
    logic [7:0] q[$];
    bit  exp_ferr = 0;
    bit  exp_ovr  = 0;
    int  exp_done = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full 8N1 frame; rd_en is raised for the cycle index pop_cyc.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_cyc);
        logic [9:0] bits;
        int d;
        bits = {stop_bit, b, 1'b0};
        d = int'(clk_div);
        frame_start_cyc = cyc;
        for (int c = 0; c < 10 * d; c++) begin
            rx    = bits[c / d];
            rd_en = (c == pop_cyc);
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    // Model of what one received frame does to the FIFO and flags.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input bit pop_same);
        if (pop_same && q.size() > 0) void'(q.pop_front());
        if (!stop_bit) begin
            exp_ferr = 1;
        end else if (q.size() < 8) begin
            q.push_back(b);
            exp_done++;
        end else begin
            exp_ovr = 1;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        send_frame(b, stop_bit, -1);
        model_frame(b, stop_bit, 0);
    endtask

    task automatic pop_check(input string tag);
        if (q.size() > 0) check({tag, "_data"}, {24'd0, rd_data}, {24'd0, q[0]});
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check({tag, "_cnt"}, {28'd0, count}, q.size());
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, {28'd0, count}, q.size());
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
        check({tag, "_full"},  {31'd0, full},  {31'd0, q.size() == 8});
        check({tag, "_ferr"},  {31'd0, frame_err}, {31'd0, exp_ferr});
        check({tag, "_ovr"},   {31'd0, overrun},   {31'd0, exp_ovr});
        check({tag, "_done"},  done_cnt, exp_done);
        if (q.size() > 0) check({tag, "_head"}, {24'd0, rd_data}, {24'd0, q[0]});
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_ferr = 0;
        exp_ovr  = 0;
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        int         lat;
        int         busy_seen;
        int         idle_seen;
        int         d;
        int         npop;
        logic [7:0] b2b [4];

        rst_n   = 1'b0;
        rx      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        clk_div = 16'd16;

        // 1: reset values while rx toggles
        for (int i = 0; i < 6; i++) begin
            rx = i[0];
            tick(1);
        end
        rx = 1'b1;
        check("rst_empty",  {31'd0, empty}, 32'd1);
        check("rst_full",   {31'd0, full}, 32'd0);
        check("rst_count",  {28'd0, count}, 32'd0);
        check("rst_rddata", {24'd0, rd_data}, 32'd0);
        check("rst_busy",   {31'd0, rx_busy}, 32'd0);
        check("rst_done",   {31'd0, rx_done}, 32'd0);
        check("rst_ferr",   {31'd0, frame_err}, 32'd0);
        check("rst_ovr",    {31'd0, overrun}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check_model("post_rst");
        check("post_rst_busy", {31'd0, rx_busy}, 32'd0);

        // 2: single frame 0x0F and its latency
        rx_frame(8'h0F, 1'b1);
        lat = last_done_cyc - frame_start_cyc;
        check("t2_latency_ok", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        check("t2_rddata", {24'd0, rd_data}, 32'h0F);
        check_model("t2");
        pop_check("t2_pop");
        check("t2_empty_after", {31'd0, empty}, 32'd1);

        // 3: back-to-back frames with no idle gap
        b2b = '{8'h0F, 8'h3D, 8'h10, 8'h33};
        for (int i = 0; i < 4; i++) rx_frame(b2b[i], 1'b1);
        tick(2);
        check_model("t3");
        for (int i = 0; i < 4; i++) begin
            check("t3_order", {24'd0, rd_data}, {24'd0, b2b[i]});
            pop_check("t3_pop");
        end

        // 4a: short glitch is rejected
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        busy_seen = 0;
        idle_seen = 0;
        for (int i = 0; i < 12 && idle_seen == 0; i++) begin
            if (rx_busy === 1'b1) busy_seen = 1;
            else if (busy_seen == 1 && i <= 8) idle_seen = 1;
            tick(1);
        end
        check("t4_glitch_busy", busy_seen, 1);
        check("t4_glitch_idle", idle_seen, 1);
        check_model("t4_glitch");

        // 4b: bad stop bit sets frame_err, then err_clr clears it
        rx_frame(8'h55, 1'b0);
        tick(40);
        check_model("t4_ferr");
        clear_errors();
        check("t4_ferr_clr", {31'd0, frame_err}, 32'd0);

        // 5: overflow with nine frames and no reads
        for (int i = 0; i < 9; i++) begin
            rx_frame(8'(i), 1'b1);
            tick(1);
            if (i == 7) check_model("t5_full8");
        end
        check_model("t5_ovr");
        for (int i = 0; i < 8; i++) pop_check("t5_pop");
        clear_errors();
        for (int i = 0; i < 8; i++) rx_frame(8'($urandom_range(0, 255)), 1'b1);
        tick(2);
        check_model("t5_refill");
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, 154);
        model_frame(b, 1'b1, 1);
        tick(2);
        check_model("t5_simul");

        while (q.size() > 0) pop_check("t5_drain");

        // 6: reset in the middle of data bit 4
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        tick(2);
        check_model("t6_pre");
        b = 8'hA5;
        for (int c = 0; c < 5 * 16 + 8; c++) begin
            rx = (c < 16) ? 1'b0 : b[(c - 16) / 16];
            tick(1);
        end
        rst_n = 1'b0;
        tick(3);
        rx = 1'b1;
        rst_n = 1'b1;
        q.delete();
        exp_ferr = 0;
        exp_ovr  = 0;
        tick(4);
        check_model("t6_rst");
        check("t6_busy", {31'd0, rx_busy}, 32'd0);
        rx_frame(8'h3C, 1'b1);
        tick(2);
        check("t6_data", {24'd0, rd_data}, 32'h3C);
        check_model("t6_post");
        pop_check("t6_pop");

        // Randomized frames, bit periods, errors and pops
        for (int n = 0; n < 24; n++) begin
            d = $urandom_range(4, 24);
            clk_div = 16'(d);
            b  = 8'($urandom_range(0, 255));
            sb = (d >= 8 && $urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            rx_frame(b, sb);
            tick(sb ? 4 : 2 * d + 8);
            check_model("rnd");
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) pop_check("rnd_pop");
            if ($urandom_range(0, 7) == 0) clear_errors();
        end
        clk_div = 16'd16;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- User-project UART receiver. Consumes the serial stream driven onto mprj_io[5] by the testbench UART transmitter, which is the upstream stage, and buffers received bytes in a small FIFO.
- The FIFO is read by the Wishbone/firmware side.
- Format is 8N1, LSB first, with a runtime-programmable bit period, frame/overrun error flags and a per-byte completion pulse.

Parameters:
- DIV_W, 16, width of the bit-period divisor.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_div  in  DIV_W  clk cycles per bit; legal range 4..2**DIV_W-1.
- rx  in  1  serial input, idle high, asynchronous to clk.
- rd_en  in  1  pop request; ignored when empty.
- rd_data  out  8  FIFO head (show-ahead); valid while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds 2**FIFO_AW bytes.
- count  out  FIFO_AW+1  number of stored bytes.
- rx_busy  out  1  high while a frame is being received (state != IDLE).
- rx_done  out  1  one-cycle pulse when a good byte is pushed.
- frame_err  out  1  sticky flag: stop bit sampled low.
- overrun  out  1  sticky flag: good byte arrived while FIFO full.
- err_clr  in  1  clears frame_err and overrun.

Behaviour:
- Reset (async assert, sync deassert use):
  - Synchronizer flops = 1, state = IDLE, FIFO pointers/count = 0.
  - empty = 1, full = 0, rd_data = 0, rx_busy = 0, rx_done = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame abandons the partial byte and flushes the FIFO.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s only.
- clk_div is latched into div_q on leaving IDLE. Changes mid-frame take effect on the next frame.
- Bit timer: down-counter, DIV_W bits. A sample event fires when the counter reaches 0, and the counter reloads div_q-1 for the next bit.
- FSM:
  - IDLE:
    - rx_s == 0 -> START, timer = (clk_div>>1) - 1.
  - START:
    - At the sample event (mid start bit): rx_s == 1 -> IDLE (glitch rejected, no flags).
    - Otherwise -> DATA, bit_idx = 0.
  - DATA:
    - At each sample event, shift rx_s into bit bit_idx (LSB first).
    - After bit_idx == 7 -> STOP.
  - STOP, at the sample event:
    - rx_s == 1 and !full (or full with simultaneous pop): push byte, pulse rx_done on the next cycle.
    - rx_s == 1 and full (no pop): drop byte, set overrun; no rx_done.
    - rx_s == 0: drop byte, set frame_err; no rx_done.
    - All cases -> IDLE the same cycle. A new start edge can therefore be detected half a bit after stop-bit centre, which supports back-to-back frames.
- Latency: the push is registered (154 +/- 1) cycles after the rx falling edge at clk_div = 16. General form: 2 + (clk_div>>1) + 9*clk_div cycles.
- FIFO (show-ahead):
  - rd_data always reflects the head entry.
  - Pop when rd_en && !empty. rd_en while empty has no effect; pointers and count are unchanged.
  - Simultaneous push and pop:
    - When full: the pop frees a slot, the push is accepted, count stays at depth, no overrun.
    - When empty: the push lands; the pop is ignored.
  - Pointers wrap modulo depth.
  - count, empty and full update on the same edge as the push/pop.
- Flags:
  - Sticky until err_clr.
  - If err_clr coincides with a new error event, the set wins.
  - Flags do not block reception.

Test Plan:
1. Reset: hold rst_n = 0, toggle rx -> all outputs at reset values. Release rst_n with rx = 1, clk_div = 16 -> state IDLE, empty = 1, count = 0.
2. Single frame 0x0F, clk_div = 16 -> rx_done pulse 154 +/- 1 cycles after the start edge. Then rd_data = 0x0F, count = 1, empty = 0. Pulse rd_en -> empty = 1.
3. Back-to-back frames 0x0F, 0x3D, 0x10, 0x33 with no idle gap -> four rx_done pulses, count = 4. Pops return 0x0F, 0x3D, 0x10, 0x33 in order; no error flags.
4. Glitch then frame error:
   - rx low for 5 cycles, then high -> no rx_done, count unchanged, rx_busy returns to 0 within 8 cycles.
   - Frame 0x55 with stop bit 0 -> frame_err = 1, count unchanged.
   - err_clr -> frame_err = 0.
5. Overflow: send 9 frames 0x00..0x08 without reads:
   - After frame 8: full = 1, count = 8. After frame 9: overrun = 1.
   - Pops return 0x00..0x07.
   - Next frame with rd_en asserted on the push cycle -> accepted, count stays 8, no overrun.
6. Reset mid-frame: assert rst_n = 0 during data bit 4 of 0xA5 with 2 bytes queued -> FIFO empty, no rx_done. The next clean frame 0x3C is received correctly.
